// File: rtl/dotpair_acc_pkg.sv
// Shared definitions for the dotpair_acc block: register map, sizes, FSM state
// and the small decode/byte-merge helpers used by the bus front end.
package dotpair_acc_pkg;

    localparam int DATA_W   = 32;
    localparam int NUM_ELEM = 8;
    localparam int NUM_RES  = 4;
    localparam int IDX_W    = 3;

    localparam logic [6:0] OFF_A     = 7'h00;
    localparam logic [6:0] OFF_B     = 7'h20;
    localparam logic [6:0] OFF_R     = 7'h40;
    localparam logic [6:0] OFF_START = 7'h50;
    localparam logic [6:0] OFF_DONE  = 7'h54;

    typedef enum logic {
        ST_IDLE,
        ST_CALC
    } state_t;

    typedef enum logic [2:0] {
        SEL_A,
        SEL_B,
        SEL_R,
        SEL_START,
        SEL_DONE,
        SEL_NONE
    } sel_t;

    // Offset is word aligned (bits [1:0] already cleared by the caller).
    function automatic sel_t decode_sel(input logic [6:0] off);
        sel_t s;
        if (off[6:5] == OFF_A[6:5]) begin
            s = SEL_A;
        end else if (off[6:5] == OFF_B[6:5]) begin
            s = SEL_B;
        end else if (off[6:4] == OFF_R[6:4]) begin
            s = SEL_R;
        end else if (off == OFF_START) begin
            s = SEL_START;
        end else if (off == OFF_DONE) begin
            s = SEL_DONE;
        end else begin
            s = SEL_NONE;
        end
        return s;
    endfunction

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old,
        input logic [DATA_W-1:0] wdata,
        input logic [3:0]        be
    );
        logic [DATA_W-1:0] r;
        r = old;
        for (int n = 0; n < 4; n++) begin
            if (be[n]) begin
                r[8*n +: 8] = wdata[8*n +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dotpair_acc_mac.sv
// Multiply-accumulate datapath: acc is the running sum including the current
// operand pair; clear restarts the sum from zero instead of the stored value.
module dotpair_mac
    import dotpair_acc_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              clear,
    input  logic              en,
    output logic [DATA_W-1:0] acc
);

    logic [DATA_W-1:0] acc_reg;
    logic [DATA_W-1:0] product;

    // Both the product and the sum wrap modulo 2^32.
    assign product = a * b;
    assign acc     = (clear ? '0 : acc_reg) + product;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_reg <= '0;
        end else if (en) begin
            acc_reg <= acc;
        end
    end

endmodule

// File: rtl/dotpair_acc.sv
// Bus-mapped pairwise dot-product engine: R[k] = A[2k]*B[2k] + A[2k+1]*B[2k+1],
// one element per cycle over an 8-cycle run started by a START write.
module dotpair_acc
    import dotpair_acc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h20000000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        bus_req,
    input  logic        bus_we,
    input  logic [31:0] bus_addr,
    input  logic [3:0]  bus_be,
    input  logic [31:0] bus_wdata,
    output logic        bus_ack,
    output logic        bus_resp,
    output logic [31:0] bus_rdata
);

    // Bus handshake: bus_ack is a same-cycle combinational accept of any
    // in-window bus_req (reads and writes alike); an accepted read returns
    // bus_resp high for exactly the following cycle with bus_rdata valid.

    state_t            state;
    state_t            next_state;
    logic [IDX_W-1:0]  idx;
    logic              done;
    logic [DATA_W-1:0] a_reg [NUM_ELEM];
    logic [DATA_W-1:0] b_reg [NUM_ELEM];
    logic [DATA_W-1:0] r_reg [NUM_RES];

    logic              in_window;
    logic [6:0]        word_off;
    sel_t              sel;
    logic [2:0]        elem;
    logic [1:0]        res_idx;
    logic              wr;
    logic              rd;
    logic              operand_wr;
    logic              start_run;
    logic              calc_en;
    logic              last_elem;
    logic [DATA_W-1:0] mac_acc;
    logic [DATA_W-1:0] read_val;

    assign in_window = (bus_addr[31:7] == BASE_ADDR[31:7]);
    assign bus_ack   = bus_req & in_window;
    assign word_off  = bus_addr[6:0] & 7'h7C;
    assign sel       = decode_sel(word_off);
    assign elem      = word_off[4:2];
    assign res_idx   = word_off[3:2];
    assign wr        = bus_ack & bus_we;
    assign rd        = bus_ack & ~bus_we;

    // Operands are frozen while a run is in flight.
    assign operand_wr = wr && (state == ST_IDLE) && ((sel == SEL_A) || (sel == SEL_B));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        start_run  = 1'b0;
        calc_en    = 1'b0;
        last_elem  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (wr && (sel == SEL_START) && bus_wdata[0]) begin
                    start_run  = 1'b1;
                    next_state = ST_CALC;
                end
            end
            ST_CALC: begin
                calc_en = 1'b1;
                if (idx == IDX_W'(NUM_ELEM - 1)) begin
                    last_elem  = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    dotpair_mac u_mac (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .a     (a_reg[idx]),
        .b     (b_reg[idx]),
        .clear (~idx[0]),
        .en    (calc_en),
        .acc   (mac_acc)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx  <= '0;
            done <= 1'b0;
            for (int n = 0; n < NUM_ELEM; n++) begin
                a_reg[n] <= '0;
                b_reg[n] <= '0;
            end
            for (int n = 0; n < NUM_RES; n++) begin
                r_reg[n] <= '0;
            end
        end else begin
            if (start_run) begin
                idx  <= '0;
                done <= 1'b0;
            end else if (calc_en) begin
                idx <= idx + IDX_W'(1);
            end
            if (last_elem) begin
                done <= 1'b1;
            end
            // Odd element closes a pair: commit the finished sum to R.
            if (calc_en && idx[0]) begin
                r_reg[idx[2:1]] <= mac_acc;
            end
            if (operand_wr && (sel == SEL_A)) begin
                a_reg[elem] <= merge_bytes(a_reg[elem], bus_wdata, bus_be);
            end
            if (operand_wr && (sel == SEL_B)) begin
                b_reg[elem] <= merge_bytes(b_reg[elem], bus_wdata, bus_be);
            end
        end
    end

    // Read data is captured from pre-edge state, so a read coinciding with
    // the DONE-setting edge still returns the old DONE.
    always_comb begin
        read_val = '0;
        case (sel)
            SEL_A:    read_val = a_reg[elem];
            SEL_B:    read_val = b_reg[elem];
            SEL_R:    read_val = r_reg[res_idx];
            SEL_DONE: read_val = {31'd0, done};
            default:  read_val = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus_resp  <= 1'b0;
            bus_rdata <= '0;
        end else begin
            bus_resp  <= rd;
            bus_rdata <= rd ? read_val : '0;
        end
    end

endmodule

// File: tb/tb_dotpair_acc.sv
// Bench for dotpair_acc: bus driver tasks feed a reference model that pushes
// expected read data; a negedge monitor pops and compares on bus_resp.
module tb_dotpair_acc;

    localparam logic [31:0] BASE = 32'h2000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic        bus_resp;
    logic [31:0] bus_rdata;

    dotpair_acc #(.BASE_ADDR(BASE)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_resp  (bus_resp),
        .bus_rdata (bus_rdata)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc++;

    bit started = 1'b0;

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] addr_q[$];

    // ---------------- reference model ----------------
    // Run started at edge run_start: element i is consumed at edge run_start+i+1,
    // R[k] lands at run_start+2k+2, DONE at run_start+8. A read at edge e sees
    // state from before e.
    logic [31:0] ma [8];
    logic [31:0] mb [8];
    logic [31:0] r_old [4];
    logic [31:0] r_new [4];
    int run_start = -1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void model_reset();
        for (int n = 0; n < 8; n++) begin
            ma[n] = 32'd0;
            mb[n] = 32'd0;
        end
        for (int k = 0; k < 4; k++) begin
            r_old[k] = 32'd0;
            r_new[k] = 32'd0;
        end
        run_start = -1;
    endfunction

    function automatic bit busy_at(input int e);
        return (run_start >= 0) && (e > run_start) && (e <= run_start + 8);
    endfunction

    function automatic logic [31:0] be_merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (d & mask) | (old & ~mask);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr, input int e);
        logic [6:0] off;
        off = addr[6:0] & 7'h7C;
        if (off < 7'h20) return ma[off[4:2]];
        if (off < 7'h40) return mb[off[4:2]];
        if (off < 7'h50) begin
            int k;
            k = int'(off[3:2]);
            return (run_start >= 0 && e > run_start + 2 * k + 2) ? r_new[k] : r_old[k];
        end
        if (off == 7'h54) return {31'd0, (run_start >= 0 && e > run_start + 8)};
        return 32'd0;
    endfunction

    function automatic void model_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] be, input int e);
        logic [6:0] off;
        off = addr[6:0] & 7'h7C;
        if (busy_at(e)) return;
        if (off < 7'h20) begin
            ma[off[4:2]] = be_merge(ma[off[4:2]], d, be);
        end else if (off < 7'h40) begin
            mb[off[4:2]] = be_merge(mb[off[4:2]], d, be);
        end else if (off == 7'h50 && d[0]) begin
            for (int k = 0; k < 4; k++) begin
                r_old[k] = r_new[k];
                r_new[k] = ma[2*k] * mb[2*k] + ma[2*k+1] * mb[2*k+1];
            end
            run_start = e;
        end
    endfunction

    // ---------------- driver tasks (entered at posedge+1) ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic bus_rd(input logic [31:0] addr);
        bit in_win;
        int e;
        in_win = (addr[31:7] == BASE[31:7]);
        e = cyc + 1;
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = addr; bus_be = 4'h0; bus_wdata = 32'd0;
        #1;
        check($sformatf("rd_ack@%h", addr), 32'(bus_ack), 32'(in_win));
        if (in_win) begin
            exp_q.push_back(model_read(addr, e));
            addr_q.push_back(addr);
        end
        @(posedge clk_i);
        #1;
        bus_req = 1'b0;
    endtask

    task automatic bus_wr(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] be);
        bit in_win;
        int e;
        in_win = (addr[31:7] == BASE[31:7]);
        e = cyc + 1;
        bus_req = 1'b1; bus_we = 1'b1; bus_addr = addr; bus_be = be; bus_wdata = d;
        #1;
        check($sformatf("wr_ack@%h", addr), 32'(bus_ack), 32'(in_win));
        @(posedge clk_i);
        #1;
        bus_req = 1'b0; bus_we = 1'b0;
        if (in_win) model_write(addr, d, be, e);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = BASE + 32'h54;
        #1;
        check("ack_during_reset", 32'(bus_ack), 32'd1);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0; bus_req = 1'b0;
        model_reset();
    endtask

    task automatic load_ops(input logic [31:0] av [8], input logic [31:0] bv [8]);
        for (int n = 0; n < 8; n++) bus_wr(BASE + 32'(4 * n), av[n], 4'hF);
        for (int n = 0; n < 8; n++) bus_wr(BASE + 32'h20 + 32'(4 * n), bv[n], 4'hF);
    endtask

    task automatic read_all_r();
        for (int k = 0; k < 4; k++) bus_rd(BASE + 32'h40 + 32'(4 * k));
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk_i) begin
        if (started) begin
            if (bus_resp) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_resp: got rdata %h with no read outstanding", bus_rdata);
                end else begin
                    check($sformatf("rdata@%h", addr_q.pop_front()), bus_rdata, exp_q.pop_front());
                end
            end else begin
                check("rdata_idle", bus_rdata, 32'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] av [8];
        logic [31:0] bv [8];

        rst_i = 1'b1; bus_req = 1'b0; bus_we = 1'b0;
        bus_addr = 32'd0; bus_be = 4'h0; bus_wdata = 32'd0;
        model_reset();
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        started = 1'b1;

        // Reset state
        check("resp_after_reset", 32'(bus_resp), 32'd0);
        bus_rd(BASE + 32'h00);
        bus_rd(BASE + 32'h3C);
        bus_rd(BASE + 32'h4C);
        bus_rd(BASE + 32'h54);
        bus_rd(BASE + 32'h50);

        // Nominal run: R = 17, 13, 74, 98; DONE polled every cycle
        av = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd8, 32'd7, 32'd6, 32'd5};
        bv = '{32'd7, 32'd5, 32'd3, 32'd1, 32'd4, 32'd6, 32'd8, 32'd10};
        load_ops(av, bv);
        bus_wr(BASE + 32'h50, 32'd1, 4'hF);
        for (int n = 0; n < 10; n++) bus_rd(BASE + 32'h54);
        read_all_r();

        // Operand write and second START during CALC
        bus_wr(BASE + 32'h50, 32'd1, 4'hF);
        bus_wr(BASE + 32'h00, 32'hFF, 4'hF);
        bus_wr(BASE + 32'h50, 32'd1, 4'hF);
        for (int n = 0; n < 10; n++) bus_rd(BASE + 32'h54);
        bus_rd(BASE + 32'h40);
        bus_rd(BASE + 32'h00);

        // Overflow wraps modulo 2^32
        bus_wr(BASE + 32'h00, 32'h0001_0000, 4'hF);
        bus_wr(BASE + 32'h04, 32'd0, 4'hF);
        bus_wr(BASE + 32'h20, 32'h0001_0000, 4'hF);
        bus_wr(BASE + 32'h24, 32'd0, 4'hF);
        bus_wr(BASE + 32'h50, 32'd1, 4'hF);
        idle(9);
        read_all_r();
        bus_rd(BASE + 32'h54);

        // Randomized runs with mid-run R reads
        for (int run = 0; run < 4; run++) begin
            for (int n = 0; n < 8; n++) bus_wr(BASE + 32'(4 * n), $urandom, 4'($urandom_range(1, 15)));
            for (int n = 0; n < 8; n++) bus_wr(BASE + 32'h20 + 32'(4 * n), $urandom, 4'($urandom_range(1, 15)));
            bus_wr(BASE + 32'h50, $urandom | 32'd1, 4'hF);
            idle($urandom_range(0, 5));
            bus_rd(BASE + 32'h40 + 32'(4 * $urandom_range(0, 3)));
            bus_rd(BASE + 32'h54);
            idle(8);
            read_all_r();
            bus_rd(BASE + 32'h54);
        end

        // START with wdata[0]=0 does nothing; DONE stays set
        bus_wr(BASE + 32'h50, 32'hFFFF_FFFE, 4'hF);
        bus_rd(BASE + 32'h54);

        // Byte enables and window boundary
        do_reset();
        bus_wr(BASE + 32'h08, 32'hAABB_CCDD, 4'b0010);
        bus_rd(BASE + 32'h08);
        bus_rd(BASE + 32'h80);
        bus_wr(BASE + 32'h80, 32'h1234_5678, 4'hF);
        bus_wr(BASE - 32'h4, 32'h1234_5678, 4'hF);
        bus_rd(BASE + 32'h00);
        bus_wr(BASE + 32'h58, 32'hDEAD_BEEF, 4'hF);
        bus_rd(BASE + 32'h58);
        bus_rd(BASE + 32'h7C);
        bus_wr(BASE + 32'h40, 32'hDEAD_BEEF, 4'hF);
        bus_rd(BASE + 32'h40);
        bus_wr(BASE + 32'h54, 32'h1, 4'hF);
        bus_rd(BASE + 32'h54);

        // Reset at CALC cycle 4 aborts the run
        for (int n = 0; n < 8; n++) begin
            av[n] = $urandom_range(1, 1000);
            bv[n] = $urandom_range(1, 1000);
        end
        load_ops(av, bv);
        bus_wr(BASE + 32'h50, 32'd1, 4'hF);
        idle(3);
        do_reset();
        bus_rd(BASE + 32'h54);
        read_all_r();
        for (int n = 0; n < 8; n++) bus_rd(BASE + 32'(4 * n));
        for (int n = 0; n < 8; n++) bus_rd(BASE + 32'h20 + 32'(4 * n));
        bus_rd(BASE + 32'h54);

        idle(3);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
